// File: rtl/imem_loader.sv
// Byte-stream program loader driving the IMEM write port (big-endian words).
// Define IMEM_LOADER_CHECKSUM_EN to add a trailing checksum byte and LD_error.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              LD_start,
    input  logic [ADDR_W-1:0] LD_base_addr,
    input  logic [CNT_W-1:0]  LD_word_count,
    input  logic [7:0]        LD_byte_in,
    input  logic              LD_byte_valid,
    output logic              LD_byte_ready,
    output logic [31:0]       LD_imem_addr,
    output logic [31:0]       LD_imem_data,
    output logic              LD_imem_wren,
    output logic              LD_busy,
    output logic              LD_done,
    output logic [CNT_W-1:0]  LD_words_written,
    output logic              LD_error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_cnt;
    logic [1:0]        byte_idx;
    logic [23:0]       word_q;
    logic [CNT_W-1:0]  wr_next;
    logic              accept;

    assign accept  = LD_byte_valid && LD_byte_ready;
    assign wr_next = LD_words_written + CNT_W'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       err_q;

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            sum_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            if (state == S_IDLE && LD_start) begin
                sum_q <= 8'd0;
                err_q <= 1'b0;
            end else if (state == S_RECV && accept) begin
                sum_q <= sum_q + LD_byte_in;
            end else if (state == S_CHECK && accept) begin
                if (8'(sum_q + LD_byte_in) != 8'd0)
                    err_q <= 1'b1;
            end
        end
    end

    assign LD_error = err_q;
`else
    assign LD_error = 1'b0;
`endif

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state            <= S_IDLE;
            cnt_q            <= '0;
            addr_cnt         <= '0;
            byte_idx         <= 2'd0;
            word_q           <= 24'd0;
            LD_byte_ready    <= 1'b0;
            LD_imem_addr     <= 32'd0;
            LD_imem_data     <= 32'd0;
            LD_imem_wren     <= 1'b0;
            LD_busy          <= 1'b0;
            LD_done          <= 1'b0;
            LD_words_written <= '0;
        end else begin
            LD_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (LD_start) begin
                        cnt_q            <= LD_word_count;
                        addr_cnt         <= LD_base_addr;
                        LD_words_written <= '0;
                        byte_idx         <= 2'd0;
                        LD_busy          <= 1'b1;
                        if (LD_word_count == '0) begin
                            state <= S_DONE;
                        end else begin
                            state         <= S_RECV;
                            LD_byte_ready <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (accept) begin
                        word_q   <= {word_q[15:0], LD_byte_in};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            LD_byte_ready <= 1'b0;
                            LD_imem_wren  <= 1'b1;
                            LD_imem_data  <= {word_q, LD_byte_in};
                            LD_imem_addr  <= {{(32-ADDR_W){1'b0}}, addr_cnt};
                            state         <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    LD_imem_wren     <= 1'b0;
                    addr_cnt         <= addr_cnt + ADDR_W'(1);
                    LD_words_written <= wr_next;
                    byte_idx         <= 2'd0;
                    if (wr_next == cnt_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        LD_byte_ready <= 1'b1;
                        state         <= S_CHECK;
`else
                        state         <= S_DONE;
`endif
                    end else begin
                        LD_byte_ready <= 1'b1;
                        state         <= S_RECV;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) begin
                        LD_byte_ready <= 1'b0;
                        state         <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    LD_done <= 1'b1;
                    LD_busy <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the pipeline's instruction fetch.
- Receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and drives the IMEM write port (address, data, write enable).
- Holds the CPU via LD_busy while loading, and signals completion with a one-cycle LD_done pulse.
- Sits between the board-level byte source (switches/UART) and the IMEM write inputs; the system's IMEM write port is currently tied to zero.

Parameters:
- ADDR_W, 8, IMEM word-address width; matches the 8-bit PC.
- CNT_W, 9, width of word count; allows 0..256 words.

Ports:
- SYS_clk  in  1  system clock; all logic on rising edge.
- SYS_reset  in  1  synchronous, active-high reset.
- LD_start  in  1  start request, sampled only in IDLE.
- LD_base_addr  in  ADDR_W  first IMEM word address, latched on accepted start.
- LD_word_count  in  CNT_W  number of words to load, latched on accepted start.
- LD_byte_in  in  8  stream byte.
- LD_byte_valid  in  1  LD_byte_in is valid.
- LD_byte_ready  out  1  loader accepts a byte this cycle.
- LD_imem_addr  out  32  IMEM write address, {24'b0, addr_cnt}.
- LD_imem_data  out  32  IMEM write data.
- LD_imem_wren  out  1  IMEM write enable, one cycle per word.
- LD_busy  out  1  load in progress; the CPU must hold its PC/stall.
- LD_done  out  1  one-cycle pulse at end of load.
- LD_words_written  out  CNT_W  words written in the current/last load.
- LD_error  out  1  checksum mismatch (optional feature only).

Behaviour:
- Reset: all outputs are registered.
  - SYS_reset=1 at a clock edge forces state=IDLE.
  - All outputs clear to 0, including LD_imem_addr, LD_imem_data and LD_words_written.
  - Byte index, assembly register and addr_cnt clear to 0.
- Reset mid-load: aborts immediately. The partial word is discarded, no write is issued, and LD_done does not pulse.
- States: IDLE, RECV, WRITE, [CHECK], DONE.
- IDLE:
  - LD_busy=0, LD_byte_ready=0.
  - On LD_start=1: latch base and count, set addr_cnt=base, clear words_written, clear LD_error, set LD_busy=1.
  - If count==0, go to DONE; otherwise go to RECV.
- RECV:
  - LD_byte_ready=1.
  - A byte is accepted when valid&&ready at the edge; it shifts in as word={word[23:0], byte}, so the first byte becomes the MSB.
  - The byte index increments 0..3. When the 4th byte is accepted, go to WRITE.
  - If valid is low, wait indefinitely with no timeout.
- WRITE (exactly one cycle):
  - LD_imem_wren=1, LD_imem_data=assembled word, LD_imem_addr={24'b0, addr_cnt}.
  - LD_byte_ready=0.
  - At exit: addr_cnt+=1, wrapping mod 2^ADDR_W (255 -> 0); words_written+=1; byte index resets to 0.
  - If the new words_written==count, go to CHECK if enabled, else DONE; otherwise go to RECV.
- Latency: wren is high in the cycle immediately after the 4th byte is accepted. Minimum per word is 5 cycles (4 accept + 1 write).
- DONE (one cycle): LD_done=1, LD_busy=0, then go to IDLE.
- Start handling: LD_start is ignored in every state except IDLE. LD_base_addr and LD_word_count changes after latch have no effect.
- Idle outputs: LD_imem_wren=0 in all states except WRITE. LD_imem_addr and LD_imem_data hold their last values.
- Wrap: base+count>256 wraps and overwrites from address 0. This is permitted and is not an error.
- LD_words_written holds its final value until the next accepted start or reset.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum of every accepted data byte, cleared on start.
  - After the last WRITE, enter CHECK with LD_byte_ready=1 and accept one checksum byte.
  - If (sum + chk) mod 256 != 0, set LD_error=1.
  - Then go to DONE. LD_error holds until the next accepted start or reset.
  - With count==0, CHECK is skipped.
- Not defined: no CHECK state and no sum register; LD_error tied to 0.

Test Plan:
- Reset, then load 1 word: base=0x00, count=1, bytes 0x20,0x08,0x00,0x05 -> one wren pulse with addr=0x00000000, data=0x20080005; LD_done one cycle later; words_written=1.
- Load 3 words: base=0x10, count=3, with valid deasserted for 2 cycles between bytes -> writes at 0x10,0x11,0x12 in order; no extra wren; ready=0 during each WRITE cycle.
- Wrap: base=0xFE, count=3 -> write addresses 0xFE, 0xFF, 0x00.
- Count=0 with start -> no wren, LD_busy high 1 cycle, then LD_done pulse; second start asserted while busy is ignored.
- Reset after 2 bytes of word 2 of a 4-word load -> no further wren, busy=0, done never pulses; subsequent start at base=0x00 loads cleanly.
- (CHECKSUM_EN) bytes 0x01,0x02,0x03,0x04 + chk 0xF6 -> LD_error=0; same bytes + chk 0x00 -> LD_error=1 at LD_done, cleared on next start.
